// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and Gray-code helpers for the write and read pointer blocks.
package fifo_pkg;

  localparam int unsigned FIFO_ADDRSIZE = 4;
  localparam int unsigned PTR_W         = FIFO_ADDRSIZE + 1;
  localparam int unsigned DEPTH         = 2 ** FIFO_ADDRSIZE;

  typedef logic [FIFO_ADDRSIZE:0] ptr_t;

  // Binary to reflected Gray.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray to binary: each bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[FIFO_ADDRSIZE] = g[FIFO_ADDRSIZE];
    for (int i = int'(FIFO_ADDRSIZE) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus crossing into the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Plain flop chain, nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wrptr_fill_monitor.sv
// Write-domain occupancy monitor: syncs the read Gray pointer, decodes both
// pointers, reports fill/free/almost-full and flags protocol violations.
module wrptr_fill_monitor
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE  = FIFO_ADDRSIZE,
  parameter int unsigned AF_THRESH = 12,
  parameter int unsigned AF_HYST   = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] wq2_rptr,
  output logic [ADDRSIZE:0] wfill,
  output logic [ADDRSIZE:0] wfree,
  output logic              walmost_full,
  output logic              err_gray,
  output logic              err_over
);

  localparam int unsigned AF_LOW = AF_THRESH - AF_HYST;

  ptr_t wq3_rptr;
  ptr_t rbin;
  ptr_t wbin;
  ptr_t fill_c;
  ptr_t free_c;
  ptr_t step_c;
  logic over_c;
  logic multi_c;
  logic af_nxt;
  logic eg_nxt;
  logic eo_nxt;

  sync_2ff #(
    .WIDTH(ADDRSIZE + 1)
  ) u_rptr_sync (
    .clk  (wclk),
    .rst_n(wrst_n),
    .d    (rptr),
    .q    (wq2_rptr)
  );

  // Decode, occupancy arithmetic, flag next-state.
  always_comb begin
    rbin    = gray2bin(ptr_t'(wq2_rptr));
    wbin    = gray2bin(ptr_t'(wptr));
    fill_c  = ptr_t'(wbin - rbin);
    over_c  = fill_c > ptr_t'(DEPTH);
    free_c  = over_c ? '0 : ptr_t'(ptr_t'(DEPTH) - fill_c);
    step_c  = ptr_t'(wq2_rptr) ^ wq3_rptr;
    multi_c = (step_c & ptr_t'(step_c - ptr_t'(1))) != '0;
    af_nxt  = walmost_full;
    if (fill_c >= ptr_t'(AF_THRESH)) begin
      af_nxt = 1'b1;
    end else if (fill_c < ptr_t'(AF_LOW)) begin
      af_nxt = 1'b0;
    end
    eg_nxt  = multi_c | (err_gray & ~err_clr);
    eo_nxt  = over_c | (err_over & ~err_clr);
  end

  // Output and history registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq3_rptr     <= '0;
      wfill        <= '0;
      wfree        <= (ADDRSIZE + 1)'(DEPTH);
      walmost_full <= 1'b0;
      err_gray     <= 1'b0;
      err_over     <= 1'b0;
    end else begin
      wq3_rptr     <= ptr_t'(wq2_rptr);
      wfill        <= (ADDRSIZE + 1)'(fill_c);
      wfree        <= (ADDRSIZE + 1)'(free_c);
      walmost_full <= af_nxt;
      err_gray     <= eg_nxt;
      err_over     <= eo_nxt;
    end
  end

endmodule

// File: tb/tb_wrptr_fill_monitor.sv
// Directed bench for wrptr_fill_monitor with a per-cycle reference model.
module tb_wrptr_fill_monitor;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b1;
  logic [4:0] rptr = '0;
  logic [4:0] wptr = '0;
  logic       err_clr = 1'b0;
  logic [4:0] wq2_rptr;
  logic [4:0] wfill;
  logic [4:0] wfree;
  logic       walmost_full;
  logic       err_gray;
  logic       err_over;

  int vectors = 0;
  int miscompares = 0;

  wrptr_fill_monitor #(
    .ADDRSIZE (4),
    .AF_THRESH(12),
    .AF_HYST  (2)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .rptr        (rptr),
    .wptr        (wptr),
    .err_clr     (err_clr),
    .wq2_rptr    (wq2_rptr),
    .wfill       (wfill),
    .wfree       (wfree),
    .walmost_full(walmost_full),
    .err_gray    (err_gray),
    .err_over    (err_over)
  );

  always #5 wclk = ~wclk;

  // Reference arithmetic straight from the pointer definitions.
  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  function automatic int g2b(input int g);
    for (int b = 0; b < 32; b++) begin
      if (gray(b) == g) return b;
    end
    return 0;
  endfunction

  function automatic int fill_of(input int w, input int r);
    return (g2b(w) - g2b(r) + 32) % 32;
  endfunction

  function automatic int free_of(input int f);
    return (f > 16) ? 0 : 16 - f;
  endfunction

  function automatic int af_of(input int f, input int cur);
    return (f >= 12) ? 1 : ((f < 10) ? 0 : cur);
  endfunction

  function automatic int multi(input int a, input int b);
    return ($countones(a ^ b) > 1) ? 1 : 0;
  endfunction

  // Model state: h1/h2/h3 are rptr as sampled 1/2/3 edges back.
  int h1, h2, h3;
  int m_fill, m_free, m_af, m_eg, m_eo;

  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      h1 <= 0; h2 <= 0; h3 <= 0;
      m_fill <= 0; m_free <= 16; m_af <= 0; m_eg <= 0; m_eo <= 0;
    end else begin
      m_fill <= fill_of(int'(wptr), h2);
      m_free <= free_of(fill_of(int'(wptr), h2));
      m_af   <= af_of(fill_of(int'(wptr), h2), m_af);
      m_eg   <= (multi(h2, h3) == 1 || (m_eg == 1 && !err_clr)) ? 1 : 0;
      m_eo   <= (fill_of(int'(wptr), h2) > 16 || (m_eo == 1 && !err_clr)) ? 1 : 0;
      h3 <= h2;
      h2 <= h1;
      h1 <= int'(rptr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  bit run = 1'b0;
  always @(negedge wclk) begin
    if (run) begin
      chk("m_wq2_rptr", int'(wq2_rptr), h2);
      chk("m_wfill", int'(wfill), m_fill);
      chk("m_wfree", int'(wfree), m_free);
      chk("m_walmost_full", int'(walmost_full), m_af);
      chk("m_err_gray", int'(err_gray), m_eg);
      chk("m_err_over", int'(err_over), m_eo);
    end
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wq2"}, int'(wq2_rptr), 0);
    chk({tag, "_wfill"}, int'(wfill), 0);
    chk({tag, "_wfree"}, int'(wfree), 16);
    chk({tag, "_af"}, int'(walmost_full), 0);
    chk({tag, "_eg"}, int'(err_gray), 0);
    chk({tag, "_eo"}, int'(err_over), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int walk [7];
    walk = '{4, 3, 2, 1, 0, 31, 30};

    #1 wrst_n = 1'b0;
    run = 1'b1;
    repeat (3) tick();
    chk_reset("rst");
    wrst_n = 1'b1;

    // Basic fill and read-pointer latency.
    tick();
    wptr = 5'b00111;
    tick();
    chk("fill5", int'(wfill), 5);
    chk("free11", int'(wfree), 11);
    rptr = 5'(gray(1));
    repeat (3) tick();
    rptr = 5'b00011;
    tick(); tick();
    chk("wq2_g2", int'(wq2_rptr), 3);
    tick();
    chk("fill3", int'(wfill), 3);

    // Hysteresis around 12 / 10.
    wptr = 5'(gray(13)); tick();
    chk("hy_f11", int'(wfill), 11); chk("hy_af11a", int'(walmost_full), 0);
    wptr = 5'(gray(14)); tick();
    chk("hy_f12", int'(wfill), 12); chk("hy_af12", int'(walmost_full), 1);
    rptr = 5'(gray(3)); repeat (3) tick();
    chk("hy_af11b", int'(walmost_full), 1);
    rptr = 5'(gray(4)); repeat (3) tick();
    chk("hy_f10", int'(wfill), 10); chk("hy_af10", int'(walmost_full), 1);
    rptr = 5'(gray(5)); repeat (3) tick();
    chk("hy_f9", int'(wfill), 9); chk("hy_af9", int'(walmost_full), 0);

    // Walk rptr backward through the wrap to rbin=30.
    foreach (walk[i]) begin
      rptr = 5'(gray(walk[i]));
      tick();
    end
    repeat (3) tick();
    chk("wr_f16a", int'(wfill), 16);
    wptr = 5'(gray(2)); tick();
    chk("wr_f4", int'(wfill), 4);
    chk("wr_free12", int'(wfree), 12);
    chk("wr_eg", int'(err_gray), 0);
    chk("wr_eo", int'(err_over), 0);

    // Full at exactly DEPTH: legal.
    rptr = 5'(gray(31)); tick();
    rptr = 5'(gray(0)); repeat (3) tick();
    wptr = 5'(gray(16)); tick();
    chk("full_f16", int'(wfill), 16);
    chk("full_free0", int'(wfree), 0);
    chk("full_af", int'(walmost_full), 1);
    chk("full_eo", int'(err_over), 0);

    // Gray violation 00000 -> 00011.
    rptr = 5'b00011;
    tick(); tick();
    chk("gv_wq2", int'(wq2_rptr), 3);
    chk("gv_eg_pre", int'(err_gray), 0);
    tick();
    chk("gv_eg_set", int'(err_gray), 1);
    tick(); tick();
    chk("gv_eg_sticky", int'(err_gray), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("gv_eg_clr", int'(err_gray), 0);

    // Overflow: wbin=17, rbin=0.
    rptr = 5'(gray(1)); tick();
    rptr = 5'(gray(0)); repeat (3) tick();
    wptr = 5'(gray(17)); tick();
    chk("ov_f17", int'(wfill), 17);
    chk("ov_free0", int'(wfree), 0);
    chk("ov_eo", int'(err_over), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ov_set_wins", int'(err_over), 1);

    // Gray set coinciding with clear; overflow ends at the same edge.
    rptr = 5'b00011;
    tick(); tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("co_eg", int'(err_gray), 1);
    chk("co_eo", int'(err_over), 0);
    chk("co_f15", int'(wfill), 15);

    // Asynchronous reset mid-traffic.
    #2 wrst_n = 1'b0;
    #1 chk_reset("arst");
    tick(); tick();
    wrst_n = 1'b1;
    repeat (4) tick();
    chk("post_wq2", int'(wq2_rptr), 3);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
